// File: rtl/act_fp16_sweep_driver.sv
// act_fp16_sweep_driver
//   Sweeps an inclusive range of fp16 codes into an activation unit over its
//   valid/ready input side. Collects the unit's results and pairs each one
//   with the code that produced it through an in-flight tag FIFO. Emits
//   (code, result) records downstream. Pairing does not depend on the unit's
//   latency.
//
// Optional feature macro: ACT_SWEEP_CHECK_EN
//   When defined, adds the nan_count and sign_err_count result checkers.
//
// Ports
//   clock, reset          single clock; asynchronous active-high reset
//   start                 launch pulse, only honoured while idle
//   first_code/last_code  inclusive sweep range; last<first wraps through 0xFFFF
//   busy, done            sweep running / one-cycle completion pulse
//   err_orphan            sticky: a result arrived with no code in flight
//   act_ivalid/act_datain/act_oready   code issue handshake to the unit
//   act_ovalid/act_dataout/act_iready  result handshake from the unit
//   rec_valid/rec_ready/rec_code/rec_result  record output handshake
//   nan_count, sign_err_count          (ACT_SWEEP_CHECK_EN only)
module act_fp16_sweep_driver #(
  parameter int TAG_DEPTH = 16,
  parameter int TAG_AW    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] first_code,
  input  logic [15:0] last_code,
  output logic        busy,
  output logic        done,
  output logic        err_orphan,
  output logic        act_ivalid,
  output logic [15:0] act_datain,
  input  logic        act_oready,
  input  logic        act_ovalid,
  input  logic [15:0] act_dataout,
  output logic        act_iready,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [15:0] rec_code,
  output logic [15:0] rec_result
`ifdef ACT_SWEEP_CHECK_EN
  ,
  output logic [16:0] nan_count,
  output logic [16:0] sign_err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW+1)'(TAG_DEPTH);

  // fp16 field helpers
  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic fp16_is_zero(input logic [15:0] x);
    return (x[14:0] == 15'h0000);
  endfunction

  state_e             state_q;
  logic [15:0]        cur_q;        // wraps naturally through 0xFFFF -> 0x0000
  logic [16:0]        remaining_q;  // 1..65536 codes still to issue
  logic               busy_q;
  logic               done_q;
  logic               err_orphan_q;
  logic               rec_valid_q;
  logic [15:0]        rec_code_q;
  logic [15:0]        rec_result_q;
  logic [15:0]        tag_mem_q [TAG_DEPTH];
  logic [TAG_AW-1:0]  wr_ptr_q;
  logic [TAG_AW-1:0]  rd_ptr_q;
  logic [TAG_AW:0]    count_q;
  logic [TAG_AW:0]    count_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               iready_s;
  logic               issue_s;
  logic               accept_s;
  logic               pop_s;
  logic               orphan_s;
  logic [15:0]        pop_code_s;
  logic [16:0]        span_s;

  assign fifo_full_s  = (count_q == FULL_CNT);
  assign fifo_empty_s = (count_q == '0);

  // Response side stays open while the record slot is free or being handed off.
  // Held low during reset so every output reads 0 while reset is asserted.
  assign iready_s = !reset && (!rec_valid_q || rec_ready);

  assign issue_s  = (state_q == ST_ISSUE) && !fifo_full_s && act_oready;
  assign accept_s = act_ovalid && iready_s;
  // A result is paired if a tag is queued or one is being pushed this cycle.
  assign pop_s    = accept_s && (!fifo_empty_s || issue_s);
  assign orphan_s = accept_s && fifo_empty_s && !issue_s;
  // Empty FIFO: forward the code being pushed straight to the record.
  assign pop_code_s = fifo_empty_s ? cur_q : tag_mem_q[rd_ptr_q];

  // Range size modulo 2^16 plus one covers both the normal and wrap-around cases.
  assign span_s = {1'b0, last_code - first_code} + 17'd1;

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_orphan = err_orphan_q;
  assign act_ivalid = (state_q == ST_ISSUE) && !fifo_full_s;
  assign act_datain = cur_q;
  assign act_iready = iready_s;
  assign rec_valid  = rec_valid_q;
  assign rec_code   = rec_code_q;
  assign rec_result = rec_result_q;

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    count_d = count_q;
    case ({issue_s, pop_s})
      2'b10:   count_d = count_q + (TAG_AW+1)'(1);
      2'b01:   count_d = count_q - (TAG_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag storage; occupancy is tracked by count_q so contents need no reset
  always_ff @(posedge clock) begin
    if (issue_s) begin
      tag_mem_q[wr_ptr_q] <= cur_q;
    end
  end

  // Sweep FSM, FIFO pointers, record register and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_q        <= 16'h0000;
      remaining_q  <= 17'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_orphan_q <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_code_q   <= 16'h0000;
      rec_result_q <= 16'h0000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_ISSUE;
            cur_q       <= first_code;
            remaining_q <= span_s;
            busy_q      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue_s) begin
            cur_q       <= cur_q + 16'd1;
            remaining_q <= remaining_q - 17'd1;
            if (remaining_q == 17'd1) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty_s && !rec_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (issue_s) begin
        wr_ptr_q <= wr_ptr_q + TAG_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + TAG_AW'(1);
      end
      count_q <= count_d;

      if (pop_s) begin
        rec_code_q   <= pop_code_s;
        rec_result_q <= act_dataout;
        rec_valid_q  <= 1'b1;
      end else if (rec_ready) begin
        rec_valid_q  <= 1'b0;
      end

      if (orphan_s) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

`ifdef ACT_SWEEP_CHECK_EN
  logic [16:0] nan_count_q;
  logic [16:0] sign_err_count_q;
  logic        sign_chk_s;

  // Sign check skips zero/NaN codes and zero results, where sign carries no meaning
  assign sign_chk_s = !fp16_is_zero(pop_code_s) && !fp16_is_nan(pop_code_s) &&
                      !fp16_is_zero(act_dataout);

  assign nan_count      = nan_count_q;
  assign sign_err_count = sign_err_count_q;

  // Result checkers, cleared when a new sweep is launched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nan_count_q      <= 17'd0;
      sign_err_count_q <= 17'd0;
    end else if ((state_q == ST_IDLE) && start) begin
      nan_count_q      <= 17'd0;
      sign_err_count_q <= 17'd0;
    end else if (pop_s) begin
      if (fp16_is_nan(act_dataout)) begin
        nan_count_q <= nan_count_q + 17'd1;
      end
      if (sign_chk_s && (pop_code_s[15] != act_dataout[15])) begin
        sign_err_count_q <= sign_err_count_q + 17'd1;
      end
    end
  end
`endif

endmodule
